// File: rtl/tft_pkg.sv
`default_nettype none
// ============================================================================
// Package  : tft_pkg
// Purpose  : Shared parameter defaults and FSM encoding for the TFT reader.
// Revision : 1.0
// ============================================================================
package tft_pkg;

    localparam int unsigned c_ADDR_W_DEFAULT     = 16;
    localparam int unsigned c_DATA_W_DEFAULT     = 8;
    localparam int unsigned c_FIFO_DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } tft_state_e;

endpackage
`default_nettype wire

// File: rtl/tft_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tft_sync_fifo
// Purpose  : Single-clock show-ahead FIFO with occupancy count and flush.
// Revision : 1.0
// ============================================================================
module tft_sync_fifo
    import tft_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT,
    parameter int DEPTH  = c_FIFO_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              w_empty;
    logic              w_full;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (c_AW+1)'(DEPTH));
    // Push and pop together always both advance, so occupancy is unchanged
    assign w_do_push = push && (!w_full || pop);
    assign w_do_pop  = pop && (!w_empty || push);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush && !reset) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign valid    = !w_empty;
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/tft_fb_reader.sv
`default_nettype none
// ============================================================================
// Module   : tft_fb_reader
// Purpose  : Streams a framebuffer region out of a 1-cycle-latency memory
//            port into a ready/valid pixel stream through a prefetch FIFO.
// Revision : 1.0
// ============================================================================
module tft_fb_reader
    import tft_pkg::*;
#(
    parameter int ADDR_W     = c_ADDR_W_DEFAULT,
    parameter int DATA_W     = c_DATA_W_DEFAULT,
    parameter int FIFO_DEPTH = c_FIFO_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [ADDR_W:0]   frame_len,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eof,
    output logic              busy,
    output logic              frame_done
);

    localparam int              c_CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0] c_LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    tft_state_e        r_state;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W:0]   r_rd_left;
    logic [ADDR_W:0]   r_pix_left;
    logic              r_pending;
    logic              r_first;
    logic              r_done;

    logic [c_CNT_W-1:0] w_fifo_count;
    logic               w_fifo_valid;
    logic [DATA_W-1:0]  w_fifo_data;
    logic               w_credit_ok;
    logic               w_issue;
    logic               w_take;
    logic               w_push;
    logic               w_last_take;

    // The in-flight read already owns a FIFO slot, so it counts against credit
    assign w_credit_ok = ({1'b0, w_fifo_count} + {{c_CNT_W{1'b0}}, r_pending})
                         < (c_CNT_W+1)'(FIFO_DEPTH);
    assign w_issue     = (r_state == FETCH) && !abort && !reset && w_credit_ok;
    assign w_take      = w_fifo_valid && pix_ready && !abort;
    assign w_push      = r_pending && !abort;
    assign w_last_take = w_take && (r_pix_left == c_LEN_ONE);

    tft_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort),
        .push      (w_push),
        .push_data (mem_readdata),
        .pop       (w_take),
        .pop_data  (w_fifo_data),
        .valid     (w_fifo_valid),
        .count     (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rd_addr  <= '0;
            r_rd_left  <= '0;
            r_pix_left <= '0;
            r_pending  <= 1'b0;
            r_first    <= 1'b0;
            r_done     <= 1'b0;
        end else if (abort) begin
            r_state    <= IDLE;
            r_rd_left  <= '0;
            r_pix_left <= '0;
            r_pending  <= 1'b0;
            r_first    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_pending <= w_issue;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (frame_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state    <= FETCH;
                            r_rd_addr  <= frame_base;
                            r_rd_left  <= frame_len;
                            r_pix_left <= frame_len;
                            r_first    <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (w_issue) begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                        r_rd_left <= r_rd_left - 1'b1;
                        if (r_rd_left == c_LEN_ONE) r_state <= DRAIN;
                    end
                end
                default: ;
            endcase
            // The final pixel cannot leave while still in FETCH, so this override is safe
            if (w_take) begin
                r_first    <= 1'b0;
                r_pix_left <= r_pix_left - 1'b1;
                if (w_last_take) begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign mem_address    = r_rd_addr;
    assign mem_chipselect = w_issue;
    assign mem_clken      = !reset;
    assign mem_write      = 1'b0;
    assign mem_writedata  = '0;
    assign pix_valid      = w_fifo_valid;
    assign pix_data       = w_fifo_valid ? w_fifo_data : '0;
    assign pix_sof        = w_fifo_valid && r_first;
    assign pix_eof        = w_fifo_valid && (r_pix_left == c_LEN_ONE);
    assign busy           = (r_state != IDLE);
    assign frame_done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tft_fb_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_tft_fb_reader
// Purpose  : Directed scoreboard bench for tft_fb_reader.
// Revision : 1.0
// ============================================================================
module tb_tft_fb_reader;

    typedef struct packed {
        logic       sof;
        logic       eof;
        logic [7:0] data;
    } pix_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] frame_base;
    logic [16:0] frame_len;
    logic [15:0] mem_address;
    logic        mem_chipselect;
    logic        mem_clken;
    logic        mem_write;
    logic [7:0]  mem_writedata;
    logic [7:0]  mem_readdata;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic        pix_eof;
    logic        busy;
    logic        frame_done;

    int   errors = 0;
    int   checks = 0;
    int   n_reads = 0;
    int   n_xfers = 0;
    int   n_done = 0;
    logic exp_done = 1'b0;
    logic prev_stall = 1'b0;
    pix_t prev_pix;

    logic [15:0] q_addr[$];
    pix_t        q_pix[$];

    tft_fb_reader #(
        .ADDR_W     (16),
        .DATA_W     (8),
        .FIFO_DEPTH (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .frame_base     (frame_base),
        .frame_len      (frame_len),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_sof        (pix_sof),
        .pix_eof        (pix_eof),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word = low byte of its address, 1-cycle read latency
    initial mem_readdata = 8'h00;
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= mem_address[7:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: reference model of frame progress, fed from observed stimulus
    always @(negedge clk) begin
        logic        idle;
        pix_t        want;
        logic [15:0] a;
        if (reset) begin
            q_addr.delete();
            q_pix.delete();
            exp_done   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            idle = (q_pix.size() == 0);
            check("busy", 32'(busy), 32'(!idle));
            check("frame_done", 32'(frame_done), 32'(exp_done));
            check("clken", 32'(mem_clken), 32'd1);
            check("write_tie", 32'({mem_write, mem_writedata}), 32'd0);
            exp_done = 1'b0;
            if (frame_done) n_done++;
            if (mem_chipselect) n_reads++;
            if (prev_stall) begin
                check("hold_valid", 32'(pix_valid), 32'd1);
                check("hold_pix", 32'({pix_sof, pix_eof, pix_data}), 32'(prev_pix));
            end
            if (abort && !idle) begin
                check("abort_no_read", 32'(mem_chipselect), 32'd0);
                q_addr.delete();
                q_pix.delete();
            end else begin
                if (mem_chipselect) begin
                    if (q_addr.size() == 0) check("spurious_read", 32'(mem_address), 32'hFFFF_FFFF);
                    else check("rd_addr", 32'(mem_address), 32'(q_addr.pop_front()));
                end
                if (pix_valid && pix_ready && !abort) begin
                    n_xfers++;
                    if (q_pix.size() == 0) begin
                        check("spurious_pixel", 32'({pix_sof, pix_eof, pix_data}), 32'hFFFF_FFFF);
                    end else begin
                        want = q_pix.pop_front();
                        check("pixel", 32'({pix_sof, pix_eof, pix_data}), 32'(want));
                        exp_done = want.eof;
                    end
                end
                check("credit", 32'((q_pix.size() - q_addr.size()) <= 8), 32'd1);
                if (start && !abort && idle) begin
                    if (frame_len == 17'd0) begin
                        exp_done = 1'b1;
                    end else begin
                        for (int k = 0; k < int'(frame_len); k++) begin
                            a = frame_base + 16'(k);
                            q_addr.push_back(a);
                            q_pix.push_back('{sof: (k == 0), eof: (k == int'(frame_len) - 1), data: a[7:0]});
                        end
                    end
                end
            end
            prev_stall = pix_valid && !pix_ready && !abort;
            prev_pix   = {pix_sof, pix_eof, pix_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_frame(input logic [15:0] base, input logic [16:0] len);
        frame_base = base;
        frame_len  = len;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        frame_base = 16'hDEAD;
        frame_len  = 17'd5;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while ((busy || pix_valid || q_pix.size() != 0) && n < max_cycles) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(n < max_cycles), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        int r0;
        int x0;
        int d0;
        int i;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        frame_base = 16'h0000;
        frame_len  = 17'd0;
        pix_ready  = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_outs", 32'({mem_chipselect, mem_clken, pix_valid, pix_sof, pix_eof, busy, frame_done}), 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_pix", 32'(pix_data), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Basic frame: first pixel two edges after start is sampled
        d0 = n_done;
        start_frame(16'h0010, 17'd4);
        @(negedge clk);
        check("lat_e0", 32'(pix_valid), 32'd0);
        tick();
        @(negedge clk);
        check("lat_e1", 32'(pix_valid), 32'd0);
        tick();
        @(negedge clk);
        check("first_pix", 32'({pix_valid, pix_sof, pix_data}), 32'h310);
        wait_idle(50);
        check("done_count1", 32'(n_done - d0), 32'd1);

        // Address wrap
        r0 = n_reads;
        start_frame(16'hFFFE, 17'd4);
        wait_idle(50);
        check("wrap_reads", 32'(n_reads - r0), 32'd4);

        // Stalled consumer: credit limit
        pix_ready = 1'b0;
        r0 = n_reads;
        start_frame(16'h0040, 17'd20);
        repeat (30) tick();
        check("stall_reads", 32'((n_reads - r0) <= 8), 32'd1);
        check("stall_valid", 32'(pix_valid), 32'd1);
        pix_ready = 1'b1;
        wait_idle(200);
        check("stall_total", 32'(n_reads - r0), 32'd20);

        // Toggling ready
        x0 = n_xfers;
        start_frame(16'h0080, 17'd16);
        i = 0;
        while ((busy || pix_valid) && i < 200) begin
            pix_ready = ~pix_ready;
            tick();
            i++;
        end
        pix_ready = 1'b1;
        wait_idle(50);
        check("toggle_xfers", 32'(n_xfers - x0), 32'd16);

        // Abort after the fifth pixel, then a fresh frame
        x0 = n_xfers;
        d0 = n_done;
        start_frame(16'h0020, 17'd16);
        i = 0;
        while (n_xfers < x0 + 5 && i < 100) begin
            tick();
            i++;
        end
        check("abort_reach", 32'(n_xfers - x0), 32'd5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_state", 32'({pix_valid, busy}), 32'd0);
        repeat (3) tick();
        check("abort_quiet", 32'(pix_valid), 32'd0);
        start_frame(16'h0100, 17'd2);
        wait_idle(50);
        check("abort_done", 32'(n_done - d0), 32'd1);

        // Zero-length frame
        r0 = n_reads;
        start_frame(16'h0200, 17'd0);
        @(negedge clk);
        check("len0_done", 32'({frame_done, busy}), 32'h2);
        tick();
        @(negedge clk);
        check("len0_pulse", 32'(frame_done), 32'd0);
        check("len0_reads", 32'(n_reads - r0), 32'd0);

        // Start while busy is ignored
        x0 = n_xfers;
        start_frame(16'h0030, 17'd4);
        tick();
        start_frame(16'h0050, 17'd3);
        wait_idle(50);
        check("busy_start", 32'(n_xfers - x0), 32'd4);

        // Abort while idle does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort", 32'({busy, pix_valid, frame_done}), 32'd0);

        // Reset mid-frame, then recovery
        pix_ready = 1'b0;
        start_frame(16'h0060, 17'd8);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pix_ready = 1'b1;
        @(negedge clk);
        check("midrst", 32'({busy, pix_valid, frame_done, mem_chipselect}), 32'd0);
        x0 = n_xfers;
        start_frame(16'h0070, 17'd2);
        wait_idle(50);
        check("post_rst", 32'(n_xfers - x0), 32'd2);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
